seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Four-digit time-multiplexing scan controller that sits directly upstream of the 7-segment decoder. It latches a 16-bit hex value, cycles through its four nibbles at a programmable rate and presents one 4-bit code per scan slot to the decoder. It also drives the matching one-hot digit enable and applies optional leading-zero blanking, so a single decoder serves four common-cathode digits.

## Interface
- SCAN_DIV, 1000: clock cycles per digit slot; legal range 1..65535.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- LOAD  in  1  capture strobe for DIN; sampled every edge.
- DIN  in  16  value to display; nibble 0 = DIN[3:0] (rightmost digit), nibble 3 = DIN[15:12].
- BLANK_EN  in  1  1 = suppress leading zeros.
- A  out  4  nibble code to the decoder input.
- DIG  out  4  one-hot digit enable, active high; DIG[i] lights digit i; 4'b0000 = all off.
- BLANK  out  1  1 = current slot is blanked; the decoder output is gated off downstream.
- FRAME  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Shadow register SHD[15:0] captures DIN on each edge with LOAD=1; it holds otherwise.
- Back-to-back LOAD: the last sampled value wins.
- LOAD never disturbs the prescaler or the digit index.
- Prescaler PCNT counts 0..SCAN_DIV-1 and wraps; the cycle with PCNT=SCAN_DIV-1 is TICK.
- SCAN_DIV=1: TICK is asserted every cycle.
- Digit index IDX (2 bits) advances on TICK in the order 0->1->2->3->0 and wraps without a gap.
- Blank condition for slot i: BLANK_EN=1, i != 0, and SHD nibbles i..3 are all zero.
- Digit 0 is never blanked, so a value of 0 shows a single "0".
- Output registers load every edge from the current IDX, SHD and BLANK_EN:
  - Not blanked: A = SHD nibble IDX, DIG = 1<<IDX, BLANK = 0.
  - Blanked: A = 4'h0, DIG = 4'b0000, BLANK = 1.
- FRAME is registered. It is 1 on the edge after the TICK where IDX goes 3->0, and 0 otherwise.
- BLANK_EN is level-sensitive and unlatched; a change takes effect on the next output update.
- Reset (asynchronous, any time, including mid-slot):
  - SHD=0, PCNT=0, IDX=0.
  - A=4'h0, DIG=4'b0000, BLANK=1, FRAME=0.
- First edge after RST_N deasserts: A=0, DIG=4'b0001, BLANK=0.

## Timing
- LOAD latency: if LOAD is sampled at edge k, SHD updates at k. A/DIG/BLANK reflect the new value at edge k+1, provided that slot's IDX is current.
- Slot advance: TICK at edge k sets IDX at k. A/DIG for the new slot appear at k+1 and are held for exactly SCAN_DIV cycles.
- Full frame = 4*SCAN_DIV cycles; FRAME period = 4*SCAN_DIV cycles.
- The first FRAME after reset arrives 4*SCAN_DIV+1 edges after reset release.
- Outputs are glitch-free: all are driven directly from flops.
- Simultaneous LOAD and TICK on the same edge: both take effect. The new slot shows the new SHD at the next edge.
- Width rules:
  - PCNT is 16 bits and is compared against SCAN_DIV-1.
  - IDX wraps by natural 2-bit overflow.
  - No arithmetic on DIN.

## Test plan
- Reset/startup: hold RST_N=0 for 5 cycles with SCAN_DIV=4 -> A=0, DIG=0000, BLANK=1, FRAME=0. After release, DIG=0001 at the first edge. DIG then steps 0001,0010,0100,1000 every 4 cycles, and FRAME pulses after 16 cycles.
- Scan content: LOAD DIN=16'h1A2F, BLANK_EN=0, SCAN_DIV=3 -> A sequence F,2,A,1 paired with DIG 0001,0010,0100,1000, each held 3 cycles, repeating.
- Leading-zero blanking: DIN=16'h0050, BLANK_EN=1 -> slots 0,1 show A=0/5 with DIG=0001/0010. Slots 2,3 show DIG=0000, BLANK=1, A=0. With DIN=16'h0000, only slot 0 is lit with A=0. With DIN=16'h0800, slot 3 is blank and slots 0..2 are lit.
- LOAD during scan: mid-slot 1, LOAD DIN=16'h00B0 -> A changes to B one edge after capture. DIG and the slot length are unchanged, and PCNT is not reset.
- Mid-operation reset: assert RST_N=0 asynchronously during slot 2 -> all outputs return to reset values without waiting for a clock edge. SHD reads 0 afterwards (A=0 in slot 0).
- SCAN_DIV=1: DIN=16'h4321 -> A cycles 1,2,3,4 on consecutive edges, and FRAME pulses every 4th cycle.

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: four-digit time-multiplexing scan controller feeding a
// shared 7-segment decoder. Latches a 16-bit value, walks its nibbles at a
// programmable slot rate and drives the one-hot digit enable, with optional
// leading-zero blanking. Every output comes straight from a flop.
module seg_scan_mux #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        blank_en,
    output logic [3:0]  a,
    output logic [3:0]  dig,
    output logic        blank,
    output logic        frame
);

    localparam logic [15:0] PCNT_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] shd;
    logic [15:0] pcnt;
    logic [1:0]  idx;
    logic        tick;
    logic        wrap_pend;
    logic [3:0]  cur_nib;
    logic        lead_zero;
    logic        cur_blank;

    assign tick = (pcnt == PCNT_LAST);

    // Shadow register: capture the display value whenever load is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd <= 16'h0000;
        end else if (load) begin
            shd <= din;
        end
    end

    // Slot prescaler and digit index; the index wraps by 2-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= 16'h0000;
            idx  <= 2'd0;
        end else if (tick) begin
            pcnt <= 16'h0000;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Pick the nibble for the current slot and decide if it is a leading zero.
    always_comb begin
        cur_nib   = shd[3:0];
        lead_zero = 1'b0;
        case (idx)
            2'd0: begin
                cur_nib   = shd[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                cur_nib   = shd[7:4];
                lead_zero = (shd[15:4] == 12'h000);
            end
            2'd2: begin
                cur_nib   = shd[11:8];
                lead_zero = (shd[15:8] == 8'h00);
            end
            default: begin
                cur_nib   = shd[15:12];
                lead_zero = (shd[15:12] == 4'h0);
            end
        endcase
        cur_blank = blank_en & lead_zero;
    end

    // Output registers reload every cycle from the current slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= 4'h0;
            dig   <= 4'b0000;
            blank <= 1'b1;
        end else if (cur_blank) begin
            a     <= 4'h0;
            dig   <= 4'b0000;
            blank <= 1'b1;
        end else begin
            a     <= cur_nib;
            dig   <= 4'b0001 << idx;
            blank <= 1'b0;
        end
    end

    // Frame marker: remember the 3->0 wrap, then pulse alongside the first
    // output cycle of digit 0 so it lines up with the new frame's display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_pend <= 1'b0;
            frame     <= 1'b0;
        end else begin
            wrap_pend <= tick && (idx == 2'd3);
            frame     <= wrap_pend;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: three instances with different slot
// lengths; the driver queues hand-derived expectations per cycle and a
// separate monitor pops and compares them at each sample point.
module tb_seg_scan_mux;

    typedef struct {
        int         dut;
        int         step;
        logic [3:0] a;
        logic [3:0] dig;
        logic       blank;
        logic       frame;
    } exp_t;

    exp_t sbQ[$];

    logic        clk;
    logic        rstN     [3];
    logic        loadIn   [3];
    logic [15:0] dinIn    [3];
    logic        blankEn  [3];
    logic [3:0]  aOut     [3];
    logic [3:0]  digOut   [3];
    logic        blankOut [3];
    logic        frameOut [3];

    int    compared   = 0;
    int    mismatched = 0;
    int    stepCnt    = 0;
    string phase      = "init";
    event  sampleEvt;

    seg_scan_mux #(.SCAN_DIV(4)) u4 (
        .clk(clk), .rst_n(rstN[0]), .load(loadIn[0]), .din(dinIn[0]),
        .blank_en(blankEn[0]), .a(aOut[0]), .dig(digOut[0]),
        .blank(blankOut[0]), .frame(frameOut[0])
    );

    seg_scan_mux #(.SCAN_DIV(3)) u3 (
        .clk(clk), .rst_n(rstN[1]), .load(loadIn[1]), .din(dinIn[1]),
        .blank_en(blankEn[1]), .a(aOut[1]), .dig(digOut[1]),
        .blank(blankOut[1]), .frame(frameOut[1])
    );

    seg_scan_mux #(.SCAN_DIV(1)) u1 (
        .clk(clk), .rst_n(rstN[2]), .load(loadIn[2]), .din(dinIn[2]),
        .blank_en(blankEn[2]), .a(aOut[2]), .dig(digOut[2]),
        .blank(blankOut[2]), .frame(frameOut[2])
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample point one time unit after every rising edge.
    always @(posedge clk) begin
        #1;
        -> sampleEvt;
    end

    // Monitor: pop one expectation per sample point and compare.
    initial begin
        forever begin
            @(sampleEvt);
            if (sbQ.size() > 0) begin
                exp_t e;
                e = sbQ.pop_front();
                compared++;
                if (aOut[e.dut] !== e.a || digOut[e.dut] !== e.dig ||
                    blankOut[e.dut] !== e.blank || frameOut[e.dut] !== e.frame) begin
                    mismatched++;
                    $display("[TB] FAIL %s#%0d dut%0d: got a=%h dig=%b blank=%b frame=%b, expected a=%h dig=%b blank=%b frame=%b",
                             phase, e.step, e.dut, aOut[e.dut], digOut[e.dut],
                             blankOut[e.dut], frameOut[e.dut], e.a, e.dig, e.blank, e.frame);
                end
            end
        end
    end

    task automatic applyStimulus(input int dut, input logic ld, input logic [15:0] val,
                                 input logic ben);
        loadIn[dut]  = ld;
        dinIn[dut]   = val;
        blankEn[dut] = ben;
    endtask

    task automatic checkOutput(input int dut, input logic [3:0] ea, input logic [3:0] ed,
                               input logic eb, input logic ef);
        exp_t e;
        e.dut   = dut;
        e.step  = stepCnt;
        e.a     = ea;
        e.dig   = ed;
        e.blank = eb;
        e.frame = ef;
        stepCnt++;
        sbQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Pulse reset across one rising edge; the following edge is edge 1.
    task automatic resetDut(input int dut);
        rstN[dut] = 1'b0;
        applyStimulus(dut, 1'b0, 16'h0000, 1'b0);
        nextCycle();
        rstN[dut] = 1'b1;
    endtask

    // Reset, capture val on edge 1, then check the per-slot table.
    task automatic scanRun(input int dut, input int s, input logic [15:0] val,
                           input logic ben, input logic [3:0] ta[4],
                           input logic [3:0] td[4], input logic tbk[4], input int frames);
        stepCnt = 0;
        resetDut(dut);
        applyStimulus(dut, 1'b1, val, ben);
        checkOutput(dut, 4'h0, 4'b0001, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(dut, 1'b0, val, ben);
        for (int n = 2; n <= frames * 4 * s + 1; n++) begin
            int slot;
            slot = ((n - 1) / s) % 4;
            checkOutput(dut, ta[slot], td[slot], tbk[slot], ((n - 1) % (4 * s)) == 0);
            nextCycle();
        end
    endtask

    // Directed test sequence.
    initial begin
        logic [3:0] ta[4];
        logic [3:0] td[4];
        logic       tbk[4];
        logic [3:0] ed;
        logic [3:0] ea;
        int         slot;

        for (int i = 0; i < 3; i++) begin
            rstN[i] = 1'b0;
            applyStimulus(i, 1'b0, 16'h0000, 1'b0);
        end

        // Reset held for 5 edges, then startup scan with SCAN_DIV=4.
        phase = "reset";
        for (int n = 0; n < 5; n++) begin
            checkOutput(0, 4'h0, 4'b0000, 1'b1, 1'b0);
            nextCycle();
        end
        rstN[0] = 1'b1;
        phase = "startup";
        stepCnt = 0;
        for (int n = 1; n <= 20; n++) begin
            ed = 4'b0001 << (((n - 1) / 4) % 4);
            checkOutput(0, 4'h0, ed, 1'b0, n == 17);
            nextCycle();
        end

        // Scan content, SCAN_DIV=3, two frames.
        phase = "scan1A2F";
        ta = '{4'hF, 4'h2, 4'hA, 4'h1};
        td = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tbk = '{1'b0, 1'b0, 1'b0, 1'b0};
        scanRun(1, 3, 16'h1A2F, 1'b0, ta, td, tbk, 2);

        // Leading-zero blanking.
        phase = "blank0050";
        ta = '{4'h0, 4'h5, 4'h0, 4'h0};
        td = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        tbk = '{1'b0, 1'b0, 1'b1, 1'b1};
        scanRun(0, 4, 16'h0050, 1'b1, ta, td, tbk, 1);

        phase = "blank0000";
        ta = '{4'h0, 4'h0, 4'h0, 4'h0};
        td = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbk = '{1'b0, 1'b1, 1'b1, 1'b1};
        scanRun(0, 4, 16'h0000, 1'b1, ta, td, tbk, 1);

        phase = "blank0800";
        ta = '{4'h0, 4'h0, 4'h8, 4'h0};
        td = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
        tbk = '{1'b0, 1'b0, 1'b0, 1'b1};
        scanRun(0, 4, 16'h0800, 1'b1, ta, td, tbk, 1);

        // LOAD in the middle of slot 1 (sampled at edge 6).
        phase = "midload";
        stepCnt = 0;
        resetDut(0);
        for (int n = 1; n <= 17; n++) begin
            applyStimulus(0, n == 6, 16'h00B0, 1'b0);
            slot = ((n - 1) / 4) % 4;
            ea = (slot == 1 && n >= 7) ? 4'hB : 4'h0;
            ed = 4'b0001 << slot;
            checkOutput(0, ea, ed, 1'b0, n == 17);
            nextCycle();
        end

        // Asynchronous reset during slot 2.
        phase = "asyncrst";
        stepCnt = 0;
        resetDut(0);
        for (int n = 1; n <= 10; n++) begin
            applyStimulus(0, n == 1, 16'h1234, 1'b0);
            slot = ((n - 1) / 4) % 4;
            ea = (n == 1) ? 4'h0 : ((slot == 0) ? 4'h4 : ((slot == 1) ? 4'h3 : 4'h2));
            ed = 4'b0001 << slot;
            checkOutput(0, ea, ed, 1'b0, 1'b0);
            nextCycle();
        end
        #2;
        rstN[0] = 1'b0;
        #1;
        checkOutput(0, 4'h0, 4'b0000, 1'b1, 1'b0);
        -> sampleEvt;
        #1;
        nextCycle();
        rstN[0] = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            checkOutput(0, 4'h0, 4'b0001, 1'b0, 1'b0);
            nextCycle();
        end

        // SCAN_DIV=1, three frames.
        phase = "div1";
        ta = '{4'h1, 4'h2, 4'h3, 4'h4};
        td = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tbk = '{1'b0, 1'b0, 1'b0, 1'b0};
        scanRun(2, 1, 16'h4321, 1'b0, ta, td, tbk, 3);

        nextCycle();
        nextCycle();
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
